game_turn_ctrl: RTL and testbench
=================================

Name: game_turn_ctrl

Overview:
- Turn sequencer and rule checker for the 3x3 board register array.
- Sits between the button front-end (cell select and move request) and the array's user write port.
- Accepts one move at a time and checks the target cell through a dedicated array read port.
- Writes the current player's mark, scans the whole board into a shadow copy, then decides win, draw or next turn.
- Also clears the board sequentially on a new-game request. The VGA port is not used.

Parameters:
ADDR_W, 4, width of cell address buses; cells 0..8 row-major, addresses 9..15 illegal
CELL_W, 2, width of a cell code; 00 empty, 01 P1, 10 P2, 11 reserved (occupied, never matches a line)
CLR_CELLS, 9, number of cells written during CLEAR

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
move_valid  in  1  move request; sampled only in IDLE
move_addr  in  ADDR_W  target cell, sampled with move_valid
new_game  in  1  level or pulse; request board clear and restart
rdata  in  CELL_W  array read data; combinational from raddr, same cycle
raddr  out  ADDR_W  array read address
waddr  out  ADDR_W  array write address (drives uaddr)
wd  out  CELL_W  array write data
wen  out  1  array write enable, one cycle per write
turn  out  1  0 = P1 to move, 1 = P2 to move
busy  out  1  high in every state except IDLE and DONE
move_done  out  1  one-cycle pulse: move written and evaluated
move_reject  out  1  one-cycle pulse: move refused
gameover  out  10  [0] P1 won, [1] P2 won, [1:0]=11 draw, [9:2] one-hot-or-more winning lines

Behaviour:

Reset:
- Synchronous, active-high. All outputs go to 0 and state goes to IDLE.
- The controller does not clear the array; the array resets itself on rst.
- Reset mid-operation aborts everything with no pulses.

States and transitions:
- States: IDLE, CHECK, WRITE, SCAN, EVAL, DONE, CLEAR.
- IDLE, on move_valid at edge E0: latch move_addr; go to CHECK.
- CHECK: raddr = latched address.
  - At E1, if address > 8 or rdata != 00: move_reject is high for the cycle after E1, then IDLE.
  - Otherwise go to WRITE.
- WRITE: for one cycle, wen=1, waddr = latched address, wd = 01 if turn=0 else 10.
- SCAN: 9 cycles. raddr steps 0..8; each rdata is captured into shadow[raddr].
  - The just-written cell must read back as the new mark (array write is visible the next cycle).
- EVAL: one cycle; decisions are registered at E12.
  - Line bits: [2] 0,1,2; [3] 3,4,5; [4] 6,7,8; [5] 0,3,6; [6] 1,4,7; [7] 2,5,8; [8] 0,4,8; [9] 2,4,6.
  - Only the mover's code is tested. A line bit is set if all three of its cells equal the mover's code.
  - If any line bit is set: gameover[turn] = 1; go to DONE.
  - Else, if all 9 cells are non-empty: gameover[1:0] = 11; go to DONE.
  - Else: toggle turn; go to IDLE.
  - move_done pulses for one cycle after E12 in all three cases (12 edges after acceptance).
  - A win on a full board reports the win, not a draw.
- DONE:
  - gameover and turn hold.
  - move_valid produces move_reject one cycle later.
  - Exit only via new_game or rst.

CLEAR and new_game:
- new_game has priority in every state. It is sampled at any edge, and the next state is CLEAR.
- An in-flight move is dropped with no done/reject pulse. A WRITE already on the bus completes that cycle only.
- CLEAR: 9 cycles, wen=1, wd=00, waddr 0..8.
- Then IDLE with turn=0 and gameover=0.
- new_game held high restarts CLEAR each cycle; the clear completes after release.

Other rules:
- move_valid while busy is ignored, not queued.
- move_valid and new_game on the same edge: new_game wins and the move is discarded.
- wen is never high outside WRITE and CLEAR.
- waddr and raddr are never above 8 while wen is high.

Test Plan:
- Reset, then move_valid with addr=4 -> wen=1, waddr=4, wd=01 at the second cycle; move_done 12 edges after acceptance; turn=1; gameover=0.
- Occupied cell: P1 plays 4, then P2 plays 4 -> move_reject one cycle after acceptance, no wen, turn stays 1. Also addr=12 -> move_reject.
- P1 plays 0,1,2 with P2 playing 3,4 -> after the third P1 move gameover=10'b0000000101, DONE; a further move_valid -> move_reject.
- Full-board draw with sequence 0,1,2,4,3,5,7,6,8 -> gameover=10'b0000000011; a final-move win variant reports the win bit only.
- new_game asserted during SCAN -> no move_done; 9 consecutive wen cycles with wd=00, waddr 0..8; then busy=0, turn=0, gameover=0.
- move_valid during busy, and move_valid together with new_game -> both ignored; rst mid-WRITE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/game_turn_ctrl.sv
// -----------------------------------------------------------------------------
// game_turn_ctrl
// Turn sequencer and rule checker for the 3x3 tic-tac-toe board register array.
// It takes one move request at a time and checks the target cell through the
// array read port. It then writes the mover's mark, scans the whole board into
// a shadow copy, and decides between win, draw and next turn. A new-game request
// clears the board cell by cell.
//
// Ports
//   clk, rst         : single clock domain, synchronous active-high reset
//   move_valid       : move request (honoured only while idle)
//   move_addr        : target cell 0..8 (row-major), 9..15 are illegal
//   new_game         : board clear / restart request, highest priority
//   rdata            : array read data, combinational from raddr
//   raddr            : array read address
//   waddr, wd, wen   : array write port
//   turn             : 0 = P1 to move, 1 = P2 to move
//   busy             : high while a move or a clear is in progress
//   move_done        : one-cycle pulse, move written and evaluated
//   move_reject      : one-cycle pulse, move refused
//   gameover         : [0] P1 won, [1] P2 won, [1:0]=11 draw, [9:2] winning lines
// All outputs are registered.
// -----------------------------------------------------------------------------
module game_turn_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int CELL_W    = 2,
    parameter int CLR_CELLS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    input  logic [ADDR_W-1:0] move_addr,
    input  logic              new_game,
    input  logic [CELL_W-1:0] rdata,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [CELL_W-1:0] wd,
    output logic              wen,
    output logic              turn,
    output logic              busy,
    output logic              move_done,
    output logic              move_reject,
    output logic [9:0]        gameover
);

    localparam int                NCELLS     = 9;
    localparam int                BOARD_W    = NCELLS * CELL_W;
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(NCELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CLR   = ADDR_W'(CLR_CELLS - 1);
    localparam logic [CELL_W-1:0] CELL_EMPTY = CELL_W'(0);
    localparam logic [CELL_W-1:0] CELL_P1    = CELL_W'(1);
    localparam logic [CELL_W-1:0] CELL_P2    = CELL_W'(2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WRITE = 3'd2,
        S_SCAN  = 3'd3,
        S_EVAL  = 3'd4,
        S_DONE  = 3'd5,
        S_CLEAR = 3'd6
    } state_e;

    // One bit per line, bit 0 = top row ... bit 7 = anti-diagonal. Only the
    // mover's exact code counts, so the reserved code 11 never completes a line.
    function automatic logic [7:0] line_hits(input logic [BOARD_W-1:0] board,
                                             input logic [CELL_W-1:0]  mark);
        logic [NCELLS-1:0] own;
        for (int i = 0; i < NCELLS; i++) begin
            own[i] = (board[i*CELL_W +: CELL_W] == mark);
        end
        line_hits = {own[2] & own[4] & own[6], own[0] & own[4] & own[8],
                     own[2] & own[5] & own[8], own[1] & own[4] & own[7],
                     own[0] & own[3] & own[6], own[6] & own[7] & own[8],
                     own[3] & own[4] & own[5], own[0] & own[1] & own[2]};
    endfunction

    function automatic logic board_full(input logic [BOARD_W-1:0] board);
        logic full;
        full = 1'b1;
        for (int i = 0; i < NCELLS; i++) begin
            full = full & (board[i*CELL_W +: CELL_W] != CELL_EMPTY);
        end
        board_full = full;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                turn_q, turn_d;
    logic [9:0]          gameover_q, gameover_d;
    logic                done_q, done_d;
    logic                reject_q, reject_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [CELL_W-1:0]   wd_q, wd_d;
    logic                wen_q, wen_d;
    logic                busy_q, busy_d;
    logic [BOARD_W-1:0]  shadow_q;
    logic [CELL_W-1:0]   mover_s;
    logic [7:0]          hits_s;
    logic                full_s;

    assign mover_s = turn_q ? CELL_P2 : CELL_P1;
    assign hits_s  = line_hits(shadow_q, mover_s);
    assign full_s  = board_full(shadow_q);

    // Next-state logic; new_game overrides every state and drops any move in flight.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        turn_d     = turn_q;
        gameover_d = gameover_q;
        done_d     = 1'b0;
        reject_d   = 1'b0;
        if (new_game) begin
            state_d    = S_CLEAR;
            cnt_d      = '0;
            turn_d     = 1'b0;
            gameover_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (move_valid) begin
                        addr_d  = move_addr;
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CHECK: begin
                    // rdata is the target cell, since raddr holds the latched address here
                    if ((addr_q > LAST_CELL) || (rdata != CELL_EMPTY)) begin
                        reject_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                end
                S_SCAN: begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                S_EVAL: begin
                    done_d = 1'b1;
                    // A win takes precedence over a full board
                    if (|hits_s) begin
                        gameover_d = {hits_s, turn_q, ~turn_q};
                        state_d    = S_DONE;
                    end else if (full_s) begin
                        gameover_d = {8'b0000_0000, 2'b11};
                        state_d    = S_DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_IDLE;
                    end
                end
                S_DONE: begin
                    reject_d = move_valid;
                end
                S_CLEAR: begin
                    if (cnt_q == LAST_CLR) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Array-port and busy values for the state being entered (they are registered).
    always_comb begin
        raddr_d = '0;
        waddr_d = '0;
        wd_d    = CELL_EMPTY;
        wen_d   = 1'b0;
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        case (state_d)
            S_CHECK: begin
                raddr_d = addr_d;
            end
            S_WRITE: begin
                wen_d   = 1'b1;
                waddr_d = addr_q;
                wd_d    = mover_s;
            end
            S_SCAN: begin
                raddr_d = cnt_d;
            end
            S_CLEAR: begin
                wen_d   = 1'b1;
                waddr_d = cnt_d;
            end
            default: begin
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            turn_q     <= 1'b0;
            gameover_q <= '0;
            done_q     <= 1'b0;
            reject_q   <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wd_q       <= '0;
            wen_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            turn_q     <= turn_d;
            gameover_q <= gameover_d;
            done_q     <= done_d;
            reject_q   <= reject_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wd_q       <= wd_d;
            wen_q      <= wen_d;
            busy_q     <= busy_d;
        end
    end

    // Shadow board capture; during SCAN raddr equals cnt_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (state_q == S_SCAN) begin
            shadow_q[int'(cnt_q)*CELL_W +: CELL_W] <= rdata;
        end else begin
            shadow_q <= shadow_q;
        end
    end

    assign raddr       = raddr_q;
    assign waddr       = waddr_q;
    assign wd          = wd_q;
    assign wen         = wen_q;
    assign turn        = turn_q;
    assign busy        = busy_q;
    assign move_done   = done_q;
    assign move_reject = reject_q;
    assign gameover    = gameover_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Testbench for game_turn_ctrl: a board array model, directed vector table,
// hand-written corner sequences and randomized play against a rules model.
module tb_game_turn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_valid;
    logic [3:0] move_addr;
    logic       new_game;
    logic [1:0] rdata;
    logic [3:0] raddr;
    logic [3:0] waddr;
    logic [1:0] wd;
    logic       wen;
    logic       turn;
    logic       busy;
    logic       move_done;
    logic       move_reject;
    logic [9:0] gameover;

    int total = 0;
    int bad   = 0;
    int wen_viol = 0;

    logic [1:0] mem [16];

    // rules model state
    int         ref_board [9];
    bit         ref_turn;
    bit         ref_done;
    logic [9:0] ref_go;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    // kind: 0 accepted, 1 refused in CHECK, 2 refused in DONE
    typedef struct {
        bit         is_ng;
        int         addr;
        int         kind;
        bit         exp_turn;
        logic [9:0] exp_go;
    } vec_t;
    vec_t tbl [31];

    game_turn_ctrl dut (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_addr(move_addr),
        .new_game(new_game), .rdata(rdata), .raddr(raddr), .waddr(waddr),
        .wd(wd), .wen(wen), .turn(turn), .busy(busy), .move_done(move_done),
        .move_reject(move_reject), .gameover(gameover)
    );

    always #5 clk = ~clk;

    // board array: resets itself, write visible next cycle, combinational read
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 2'b00;
        end else if (wen) begin
            mem[waddr] <= wd;
        end
    end
    assign rdata = mem[raddr];

    always @(negedge clk) begin
        if (wen && ((waddr > 4'd8) || (raddr > 4'd8))) wen_viol <= wen_viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_board();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[i*2 +: 2] = mem[i];
        return 32'(b);
    endfunction

    function automatic logic [31:0] ref_packed();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[i*2 +: 2] = 2'(ref_board[i]);
        return 32'(b);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) ref_board[i] = 0;
        ref_turn = 1'b0;
        ref_done = 1'b0;
        ref_go   = 10'd0;
    endtask

    task automatic model_move(input int a, output int kind, output logic [1:0] wdx);
        int  mark;
        bit  full;
        wdx  = ref_turn ? 2'b10 : 2'b01;
        mark = ref_turn ? 2 : 1;
        kind = 0;
        if (ref_done) begin
            kind = 2;
        end else if (a > 8) begin
            kind = 1;
        end else if (ref_board[a] != 0) begin
            kind = 1;
        end else begin
            ref_board[a] = mark;
            ref_go = 10'd0;
            for (int l = 0; l < 8; l++) begin
                if (ref_board[lines[l][0]] == mark && ref_board[lines[l][1]] == mark &&
                    ref_board[lines[l][2]] == mark) ref_go[2+l] = 1'b1;
            end
            full = 1'b1;
            for (int i = 0; i < 9; i++) if (ref_board[i] == 0) full = 1'b0;
            if (ref_go != 10'd0) begin
                ref_go[ref_turn] = 1'b1;
                ref_done = 1'b1;
            end else if (full) begin
                ref_go = 10'b0000000011;
                ref_done = 1'b1;
            end else begin
                ref_turn = ~ref_turn;
            end
        end
    endtask

    task automatic check_move(input int a, input int kind, input bit exp_turn,
                              input logic [9:0] exp_go, input logic [1:0] exp_wd, input string tag);
        int lat = -1, wcnt = 0, wk = -1;
        logic [3:0] wa = 4'd0;
        logic [1:0] wdv = 2'd0;
        bit gd = 1'b0, gr = 1'b0;
        @(negedge clk);
        move_valid = 1'b1;
        move_addr  = 4'(a);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                move_valid = 1'b0;
                move_addr  = 4'd0;
            end
            if (wen) begin
                wcnt++; wk = k; wa = waddr; wdv = wd;
            end
            if (move_done || move_reject) begin
                lat = k; gd = move_done; gr = move_reject;
                break;
            end
        end
        case (kind)
            0: begin
                chk({tag, ".done_lat"}, 32'(lat), 32'd12);
                chk({tag, ".done"}, 32'(gd), 32'd1);
                chk({tag, ".wen_cnt"}, 32'(wcnt), 32'd1);
                chk({tag, ".wen_cycle"}, 32'(wk), 32'd1);
                chk({tag, ".waddr"}, 32'(wa), 32'(a));
                chk({tag, ".wd"}, 32'(wdv), 32'(exp_wd));
            end
            1: begin
                chk({tag, ".rej_lat"}, 32'(lat), 32'd1);
                chk({tag, ".rej"}, 32'(gr), 32'd1);
                chk({tag, ".rej_nowen"}, 32'(wcnt), 32'd0);
            end
            default: begin
                chk({tag, ".done_rej_lat"}, 32'(lat), 32'd0);
                chk({tag, ".done_rej"}, 32'(gr), 32'd1);
                chk({tag, ".done_nowen"}, 32'(wcnt), 32'd0);
            end
        endcase
        @(negedge clk);
        chk({tag, ".pulse_width"}, 32'({move_done, move_reject}), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".turn"}, 32'(turn), 32'(exp_turn));
        chk({tag, ".gameover"}, 32'(gameover), 32'(exp_go));
    endtask

    task automatic do_newgame();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // new_game (and possibly move_valid) was raised at the previous negedge
    task automatic clear_monitor(input string tag);
        int seq [$];
        int first = -1, last = -1, badwd = 0, pulses = 0;
        bit ok;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (j == 0) begin
                new_game   = 1'b0;
                move_valid = 1'b0;
            end
            if (wen) begin
                if (first < 0) first = j;
                last = j;
                seq.push_back(int'(waddr));
                if (wd != 2'b00) badwd++;
            end
            if (move_done || move_reject) pulses++;
        end
        ok = (seq.size() == 9) && ((last - first) == 8);
        foreach (seq[i]) if (seq[i] != i) ok = 1'b0;
        chk({tag, ".clr_seq"}, 32'(ok), 32'd1);
        chk({tag, ".clr_wd"}, 32'(badwd), 32'd0);
        chk({tag, ".clr_nopulse"}, 32'(pulses), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".turn"}, 32'(turn), 32'd0);
        chk({tag, ".gameover"}, 32'(gameover), 32'd0);
        chk({tag, ".board"}, dut_board(), 32'd0);
    endtask

    initial begin
        bit   prev_turn;
        int   kind;
        int   a;
        int   lat;
        int   extra;
        logic [1:0] wdx;

        rst = 1'b1; move_valid = 1'b0; move_addr = 4'd0; new_game = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.raddr", 32'(raddr), 32'd0);
        chk("rst.waddr", 32'(waddr), 32'd0);
        chk("rst.wd", 32'(wd), 32'd0);
        chk("rst.wen", 32'(wen), 32'd0);
        chk("rst.turn", 32'(turn), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(move_done), 32'd0);
        chk("rst.reject", 32'(move_reject), 32'd0);
        chk("rst.gameover", 32'(gameover), 32'd0);
        rst = 1'b0;

        // directed vectors: first move, rejects, row win, draw, full-board win
        tbl[0]  = '{0, 4, 0, 1, 10'h000};
        tbl[1]  = '{0, 4, 1, 1, 10'h000};
        tbl[2]  = '{0, 12, 1, 1, 10'h000};
        tbl[3]  = '{1, 0, 0, 0, 10'h000};
        tbl[4]  = '{0, 0, 0, 1, 10'h000};
        tbl[5]  = '{0, 3, 0, 0, 10'h000};
        tbl[6]  = '{0, 1, 0, 1, 10'h000};
        tbl[7]  = '{0, 4, 0, 0, 10'h000};
        tbl[8]  = '{0, 2, 0, 0, 10'h005};
        tbl[9]  = '{0, 5, 2, 0, 10'h005};
        tbl[10] = '{1, 0, 0, 0, 10'h000};
        tbl[11] = '{0, 0, 0, 1, 10'h000};
        tbl[12] = '{0, 1, 0, 0, 10'h000};
        tbl[13] = '{0, 2, 0, 1, 10'h000};
        tbl[14] = '{0, 4, 0, 0, 10'h000};
        tbl[15] = '{0, 3, 0, 1, 10'h000};
        tbl[16] = '{0, 5, 0, 0, 10'h000};
        tbl[17] = '{0, 7, 0, 1, 10'h000};
        tbl[18] = '{0, 6, 0, 0, 10'h000};
        tbl[19] = '{0, 8, 0, 0, 10'h003};
        tbl[20] = '{1, 0, 0, 0, 10'h000};
        tbl[21] = '{0, 0, 0, 1, 10'h000};
        tbl[22] = '{0, 1, 0, 0, 10'h000};
        tbl[23] = '{0, 2, 0, 1, 10'h000};
        tbl[24] = '{0, 3, 0, 0, 10'h000};
        tbl[25] = '{0, 5, 0, 1, 10'h000};
        tbl[26] = '{0, 4, 0, 0, 10'h000};
        tbl[27] = '{0, 7, 0, 1, 10'h000};
        tbl[28] = '{0, 6, 0, 0, 10'h000};
        tbl[29] = '{0, 8, 0, 0, 10'h081};
        tbl[30] = '{1, 0, 0, 0, 10'h000};

        prev_turn = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (tbl[i].is_ng) begin
                do_newgame();
                chk($sformatf("vec%0d.ng_turn", i), 32'(turn), 32'd0);
                chk($sformatf("vec%0d.ng_go", i), 32'(gameover), 32'd0);
                chk($sformatf("vec%0d.ng_board", i), dut_board(), 32'd0);
                prev_turn = 1'b0;
            end else begin
                check_move(tbl[i].addr, tbl[i].kind, tbl[i].exp_turn, tbl[i].exp_go,
                           prev_turn ? 2'b10 : 2'b01, $sformatf("vec%0d", i));
                prev_turn = tbl[i].exp_turn;
            end
        end

        // new_game during SCAN drops the move and clears the board
        check_move(0, 0, 1'b1, 10'h000, 2'b01, "pre_scan");
        @(negedge clk);
        move_valid = 1'b1; move_addr = 4'd4;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (4) @(negedge clk);
        new_game = 1'b1;
        clear_monitor("ng_scan");

        // move_valid while busy is ignored
        extra = 0;
        lat = -1;
        @(negedge clk);
        move_valid = 1'b1; move_addr = 4'd0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0 || k == 3) move_valid = 1'b0;
            if (k == 2) begin
                move_valid = 1'b1; move_addr = 4'd1;
            end
            if (move_reject) extra++;
            if (move_done) begin
                lat = k;
                break;
            end
        end
        move_valid = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (wen || move_done || move_reject) extra++;
        end
        chk("busy_ign.done_lat", 32'(lat), 32'd12);
        chk("busy_ign.no_activity", 32'(extra), 32'd0);
        chk("busy_ign.turn", 32'(turn), 32'd1);
        chk("busy_ign.board", dut_board(), 32'h1);

        // move_valid together with new_game: the clear wins
        @(negedge clk);
        move_valid = 1'b1; move_addr = 4'd2; new_game = 1'b1;
        clear_monitor("mv_ng");

        // reset while the write is on the bus
        @(negedge clk);
        move_valid = 1'b1; move_addr = 4'd3;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        chk("rst_wr.wen_before", 32'(wen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr.outputs", 32'({raddr, waddr, wd, wen, turn, busy, move_done, move_reject, gameover}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr.board", dut_board(), 32'd0);

        // randomized play against the rules model
        model_clear();
        for (int n = 0; n < 200; n++) begin
            if (ref_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0)) begin
                do_newgame();
                model_clear();
                chk($sformatf("rnd%0d.ng_turn", n), 32'(turn), 32'd0);
                chk($sformatf("rnd%0d.ng_go", n), 32'(gameover), 32'd0);
            end else begin
                a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
                model_move(a, kind, wdx);
                check_move(a, kind, ref_turn, ref_go, wdx, $sformatf("rnd%0d", n));
            end
            chk($sformatf("rnd%0d.board", n), dut_board(), ref_packed());
        end

        chk("wen_addr_range", 32'(wen_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
